fifo_tx_scheduler: RTL
======================

Name: fifo_tx_scheduler

Overview:
Shares the single write port of the 8-bit TX FIFO among NREQ byte producers using round-robin arbitration. Sequences the FIFO read side into the UART transmitter with a pop/start/wait-done state machine. Sits between the producer blocks and the fifo + uart_tx pair, and exposes a transmitted-byte counter for status.

Parameters:
NREQ, 4, number of requesters (2..8).
IDW, $clog2(NREQ), width of grant index (derived, not overridden).
CNTW, 16, width of transmitted-byte counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  1 = accept new requests and start new transmissions.
req_valid  input  NREQ  per-requester byte valid.
req_data  input  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
req_ready  output  NREQ  one-hot accept strobe; byte taken when valid&ready.
grant_id  output  IDW  index of requester accepted this cycle (valid when fifo_wr=1).
fifo_wr  output  1  FIFO push.
fifo_wdata  output  8  FIFO write data.
fifo_full  input  1  FIFO full flag.
fifo_rd  output  1  FIFO pop.
fifo_rdata  input  8  FIFO head data (show-ahead, combinational from read pointer).
fifo_empty  input  1  FIFO empty flag.
tx_start  output  1  one-cycle start pulse to UART TX.
tx_data  output  8  byte to transmit, registered, stable from tx_start until next load.
tx_busy  input  1  UART TX busy.
tx_done  input  1  one-cycle pulse when UART TX finishes a byte.
tx_count  output  CNTW  number of bytes completed (tx_done seen in WAIT_DONE).

Behaviour:
Reset values: req_ready=0, fifo_wr=0, fifo_wdata=0, grant_id=0, fifo_rd=0, tx_start=0, tx_data=0, tx_count=0, rr_ptr=0, state=IDLE.
Write side (combinational grant, registered pointer):
- Request set is eligible when enable=1, fifo_full=0 and at least one req_valid=1.
- Winner is the first set req_valid bit searching from rr_ptr upward, wrapping modulo NREQ.
- When eligible: fifo_wr=1, fifo_wdata=winner's byte, req_ready[winner]=1, grant_id=winner; all other req_ready bits are 0.
- When not eligible: fifo_wr=0 and req_ready=0.
- Zero latency: the byte is pushed in the same cycle it is accepted. Maximum one byte per cycle.
- On an accepted write, rr_ptr <= (winner+1) mod NREQ. Otherwise rr_ptr holds.
- fifo_full=1 blocks all grants. A requester holds valid and data until it sees ready.
Read side FSM, outputs registered from state:
- IDLE: if enable=1, fifo_empty=0 and tx_busy=0 -> LOAD, with tx_data <= fifo_rdata captured at that edge.
- LOAD (exactly 1 cycle): fifo_rd=1, tx_start=1 -> WAIT_DONE.
- WAIT_DONE: fifo_rd=0, tx_start=0. On tx_done=1: tx_count <= tx_count+1 (wraps at 2^CNTW), -> IDLE.
- tx_done outside WAIT_DONE is ignored.
- Minimum byte spacing: done at cycle t -> next tx_start at t+2.
- Simultaneous push and pop in the same cycle are both issued; the FIFO resolves them.
- Pop occurs only in LOAD, entered only when empty=0, so a pop is never issued to an empty FIFO.
- enable=0: no new grants and no new IDLE->LOAD transition. A byte already in LOAD or WAIT_DONE completes normally.
- Reset mid-operation: asynchronous return to the reset values above. tx_start and fifo_rd deassert immediately, any pending byte is dropped, and tx_count clears.

Test Plan:
Single requester: NREQ=4, req0 sends 0xA5, FIFO empty, uart idle -> fifo_wr 1 cycle with 0xA5, req_ready=4'b0001. tx_data=0xA5 and tx_start pulse 2 cycles later, fifo_rd in the same cycle. After tx_done, tx_count=1.
Round-robin fairness: all four valid continuously with bytes 0x10,0x21,0x32,0x43, rr_ptr=0 -> grant sequence 0,1,2,3,0 on consecutive cycles; FIFO receives 0x10,0x21,0x32,0x43,0x10.
Full backpressure: FIFO depth 8, uart tx_busy held 1 -> 8 writes accepted, then fifo_full=1, req_ready=0 and no fifo_wr. Release tx_busy, one pop completes -> exactly one further grant.
Back-to-back drain: 3 bytes 0x01,0x02,0x03 in FIFO, tx_done 10 cycles after each start -> tx_data in order 0x01,0x02,0x03. Each tx_start follows the previous tx_done by exactly 2 cycles. tx_count=3 at the end, fifo_empty=1.
Enable gating: enable drops during WAIT_DONE with 2 bytes queued -> current byte completes and tx_count increments. No further tx_start and no grants while enable=0. Raising enable resumes from the held rr_ptr.
Async reset mid-transfer: assert rst during LOAD -> tx_start=0, fifo_rd=0, tx_count=0 without waiting for a clock edge. After release, state=IDLE and the first grant goes to requester 0.

Source files
------------

// File: rtl/fifo_tx_scheduler.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : fifo_tx_scheduler
// Brief    : Round-robin arbiter for the TX FIFO write port plus the
//            pop/start/wait-done sequencer that feeds the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_tx_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [IDW-1:0]       grant_id,
  output logic                 fifo_wr,
  output logic [7:0]           fifo_wdata,
  input  logic                 fifo_full,
  output logic                 fifo_rd,
  input  logic [7:0]           fifo_rdata,
  input  logic                 fifo_empty,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [CNTW-1:0]      tx_count
);

  localparam logic [IDW:0] c_NREQ = NREQ[IDW:0];
  localparam logic [IDW:0] c_ONE  = {{IDW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    w_rr_nxt;
  logic [IDW-1:0]    w_win_id;
  logic [IDW:0]      w_cand;
  logic [IDW:0]      w_win_inc;
  logic              w_found;
  logic              w_grant;
  logic              w_load;
  logic              w_done;
  logic              r_start;
  logic [7:0]        r_tx_data;
  logic [CNTW-1:0]   r_tx_count;

  // Search upward from the pointer, wrapping modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    w_cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + k[IDW:0];
      if (w_cand >= c_NREQ) begin
        w_cand = w_cand - c_NREQ;
      end
      if (!w_found && req_valid[w_cand[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_win_id = w_cand[IDW-1:0];
      end
    end
  end

  assign w_grant = !rst && enable && !fifo_full && w_found;

  always_comb begin
    req_ready  = '0;
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    grant_id   = '0;
    if (w_grant) begin
      req_ready[w_win_id] = 1'b1;
      fifo_wr             = 1'b1;
      fifo_wdata          = req_data[{w_win_id, 3'b000} +: 8];
      grant_id            = w_win_id;
    end
  end

  always_comb begin
    w_win_inc = {1'b0, w_win_id} + c_ONE;
    w_rr_nxt  = (w_win_inc == c_NREQ) ? '0 : w_win_inc[IDW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && !fifo_empty && !tx_busy) begin
          w_state_nxt = LOAD;
          w_load      = 1'b1;
        end
      end
      LOAD: begin
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The start/pop flop is set on the edge entering LOAD, so it is high exactly while in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_start    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_load;
      if (w_load) begin
        r_tx_data <= fifo_rdata;
      end
      if (w_done) begin
        r_tx_count <= r_tx_count + 1'b1;
      end
    end
  end

  assign fifo_rd  = r_start;
  assign tx_start = r_start;
  assign tx_data  = r_tx_data;
  assign tx_count = r_tx_count;

endmodule
`default_nettype wire
